spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised SPI slave (receiver) for the SPI subsystem. It supports all four CPOL/CPHA modes with correct leading/trailing-edge sampling, a configurable word width and bit order, and continuous multi-word frames while SS stays low. Transmit data arrives through a valid/ready holding buffer, and each received word is presented as a one-cycle pulse. It sits between an SPI master (SCK/MOSI/MISO/SS) and local logic clocked by `clk`, and all SPI inputs are treated as asynchronous.

## Interface
- `DATA_W`, default 16: bits per word; must be ≥ 2.
- `MSB_FIRST`, default 0: 0 shifts the LSB first, 1 shifts the MSB first; applies to both MOSI and MISO.
- `SYNC_STAGES`, default 2: synchroniser depth for `sck`, `ss_n`, `mosi`; must be ≥ 2.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous reset, active-low.
- `cpol`  in  1: SCK idle level; sampled only while idle.
- `cpha`  in  1: 0 means sample on leading edge, 1 means sample on trailing edge; sampled only while idle.
- `ss_n`  in  1: slave select, active-low, asynchronous.
- `sck`  in  1: serial clock from master, asynchronous.
- `mosi`  in  1: serial data in, asynchronous.
- `miso`  out  1: serial data out.
- `miso_oe`  out  1: MISO output enable; high only while selected.
- `tx_data`  in  DATA_W: next word to transmit.
- `tx_valid`  in  1: `tx_data` valid.
- `tx_ready`  out  1: holding buffer empty.
- `rx_data`  out  DATA_W: last complete received word; held until the next word completes.
- `rx_valid`  out  1: one-cycle pulse when a word completes.
- `tx_underrun`  out  1: one-cycle pulse when a word starts with the buffer empty.
- `busy`  out  1: high in LOAD and SHIFT.

## Operation
- **Reset** (`rst`=0 at a clk edge): state IDLE, `bit_cnt`=0, shift register 0, buffer empty.
  - Outputs: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0.
  - Synchroniser flops reset to `sck`=`cpol` level and `ss_n`=1.
  - Reset mid-transfer aborts with no `rx_valid`.
- **Holding buffer**: a `tx_valid && tx_ready` cycle captures `tx_data` and drops `tx_ready`. `tx_ready` returns high the cycle after the buffer transfers into the shift register.
- **Edges**: leading edge = `sck` leaves the `cpol` level; trailing edge = `sck` returns to it.
  - CPHA=0: sample on leading, shift/drive on trailing.
  - CPHA=1: drive on leading, sample on trailing.
- **States**:
  - IDLE: `miso_oe`=0; `cpol`/`cpha` latched. A synchronised `ss_n` fall moves to LOAD.
  - LOAD (1 cycle):
    - Shift register ← buffer, or all-zero with a `tx_underrun` pulse if the buffer is empty.
    - `bit_cnt`=0 and `miso_oe`=1.
    - `miso` ← first bit (bit 0, or bit DATA_W-1 if `MSB_FIRST`).
    - Go to SHIFT.
  - SHIFT:
    - Each sample edge captures `mosi` into the receive shift register and increments `bit_cnt`.
    - Each drive edge advances `miso` to the next bit, except the trailing edge of CPHA=0 after the final sample.
    - When `bit_cnt` reaches DATA_W, the same clk edge sets `rx_data` to the assembled word, pulses `rx_valid`, wraps `bit_cnt` to 0 and reloads the transmit shift register exactly as in LOAD. This reload supports back-to-back words.
- **SS rise** (synchronised) in any state: go to IDLE next cycle.
  - `miso_oe`=0 and `miso`=0; a partial word is discarded with no `rx_valid`.
  - A word already moved into the shift register is consumed, not restored.
  - If SS rises on the same cycle a word completes, `rx_valid` still pulses.
- `cpol`/`cpha` changes while `busy`=1 are ignored until IDLE.

## Timing
- Input-to-detection latency: SYNC_STAGES+1 clk cycles from a pin edge to the edge strobe.
- Master constraints:
  - SCK high and low phases each ≥ SYNC_STAGES+2 clk periods.
  - SS-fall to first SCK edge ≥ SYNC_STAGES+3 clk periods.
- `rx_valid` is high for exactly 1 cycle, the cycle after the clk edge that registers the final sample.
- `miso` changes 1 clk after the detected drive edge; the master samples at least a half SCK period later.
- Buffer reload per word leaves the host at least one full word time to refill before the next underrun.

## Structure
- Package `spi_pkg`:
  - state enum `spi_state_t` (IDLE, LOAD, SHIFT);
  - mode constants `SPI_MODE0`..`SPI_MODE3` as 2-bit {cpol, cpha};
  - bit-index helper function for the `MSB_FIRST` ordering.
- Sub-module `spi_sync_edge` (parameter STAGES): synchroniser plus rise/fall strobes. Instantiated for `sck` and `ss_n`; `mosi` uses the synchroniser only.

## Test plan
- Mode 0, DATA_W=16, LSB first; tx 16'hA5C3, master sends 16'h1234 → master reads A5C3, `rx_data`=1234 with a single `rx_valid` pulse.
- Modes 1, 2, 3 with the same data, plus `MSB_FIRST`=1 → identical words in both directions; no bit shifted between modes.
- Three back-to-back words with one SS assertion; the buffer is refilled after each `tx_ready` → 3 `rx_valid` pulses, correct words, no `tx_underrun`.
- SS asserted with an empty buffer → `tx_underrun` pulse; MISO sends 0x0000; RX still correct.
- SS deasserted after 7 bits → no `rx_valid`, `miso_oe`=0, return to IDLE; the next frame is fully correct.
- `rst` low mid-word → all outputs at reset values next cycle; `tx_ready`=1.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI slave.
//   spi_state_t       - slave control states (IDLE, LOAD, SHIFT)
//   SPI_MODE0..3      - {cpol, cpha} mode encodings
//   bitIndex()        - maps a serial bit position to a word bit index
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Serial position idx travels as word bit idx (LSB first) or width-1-idx (MSB first).
    function automatic int bitIndex(input int idx, input int width, input logic msbFirst);
        return msbFirst ? (width - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous input with
// registered rise/fall strobes.
//   clk          - system clock
//   rst          - synchronous reset, active-low
//   i_async      - asynchronous input pin
//   i_resetLevel - level the synchroniser assumes while in reset
//   o_rise       - one-cycle strobe, STAGES+1 cycles after a pin rise
//   o_fall       - one-cycle strobe, STAGES+1 cycles after a pin fall
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    input  logic i_resetLevel,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    // Shift the pin through the chain; strobes compare the last stage with its previous value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= {STAGES{i_resetLevel}};
            r_prev <= i_resetLevel;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave supporting all four CPOL/CPHA modes,
// continuous multi-word frames and a single-word transmit holding buffer.
//   clk, rst           - system clock, synchronous active-low reset
//   cpol, cpha         - SPI mode, latched while idle
//   ss_n, sck, mosi    - asynchronous SPI inputs from the master
//   miso, miso_oe      - serial data out and its output enable
//   tx_data/valid/ready- transmit holding buffer handshake
//   rx_data, rx_valid  - last received word and its completion pulse
//   tx_underrun        - pulse when a word starts with an empty buffer
//   busy               - high in LOAD and SHIFT
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              ss_n,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W     = $clog2(DATA_W);
    localparam int FIRST_IDX = bitIndex(0, DATA_W, MSB_FIRST != 0);

    spi_state_t              r_state;
    logic                    r_cpol;
    logic                    r_cpha;
    logic [CNT_W-1:0]        r_bitCnt;
    logic [DATA_W-1:0]       r_txWord;
    logic [DATA_W-1:0]       r_rxWord;
    logic [DATA_W-1:0]       r_bufData;
    logic                    r_bufFull;
    logic [DATA_W-1:0]       r_rxData;
    logic                    r_rxValid;
    logic                    r_txUnderrun;
    logic                    r_miso;
    logic                    r_misoOe;
    logic [SYNC_STAGES-1:0]  r_mosiSync;

    logic                    w_sckRise;
    logic                    w_sckFall;
    logic                    w_ssRise;
    logic                    w_ssFall;
    logic                    w_mosi;
    logic                    w_sampleEdge;
    logic                    w_driveEdge;
    logic [CNT_W-1:0]        w_bitIdx;
    logic [DATA_W-1:0]       w_rxNext;
    logic [DATA_W-1:0]       w_loadWord;
    logic                    w_lastBit;

    // SCK idles at the cpol level, so reset the synchroniser there to avoid a phantom edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sckSync (
        .clk          (clk),
        .rst          (rst),
        .i_async      (sck),
        .i_resetLevel (cpol),
        .o_rise       (w_sckRise),
        .o_fall       (w_sckFall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ssSync (
        .clk          (clk),
        .rst          (rst),
        .i_async      (ss_n),
        .i_resetLevel (1'b1),
        .o_rise       (w_ssRise),
        .o_fall       (w_ssFall)
    );

    // MOSI has the same depth as SCK, so at a strobe it reflects the pin around the SCK edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mosiSync <= '0;
        end else begin
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
        end
    end
    assign w_mosi = r_mosiSync[SYNC_STAGES-1];

    // Leading edge leaves the cpol level; CPHA picks which edge samples and which drives.
    always_comb begin
        w_sampleEdge = 1'b0;
        w_driveEdge  = 1'b0;
        case ({r_cpol, r_cpha})
            SPI_MODE0: begin w_sampleEdge = w_sckRise; w_driveEdge = w_sckFall; end
            SPI_MODE1: begin w_sampleEdge = w_sckFall; w_driveEdge = w_sckRise; end
            SPI_MODE2: begin w_sampleEdge = w_sckFall; w_driveEdge = w_sckRise; end
            SPI_MODE3: begin w_sampleEdge = w_sckRise; w_driveEdge = w_sckFall; end
            default:   begin w_sampleEdge = 1'b0;      w_driveEdge = 1'b0;      end
        endcase
    end

    // Transmit and receive share one bit position, indexed rather than shifted.
    assign w_bitIdx   = CNT_W'(bitIndex(int'(r_bitCnt), DATA_W, MSB_FIRST != 0));
    assign w_loadWord = r_bufFull ? r_bufData : '0;
    assign w_lastBit  = (r_bitCnt == CNT_W'(DATA_W - 1));

    always_comb begin
        w_rxNext           = r_rxWord;
        w_rxNext[w_bitIdx] = w_mosi;
    end

    // Control FSM. A drive edge presents bit[bit_cnt]; after the final sample the count
    // wraps to 0, so the CPHA=0 trailing edge that follows re-presents the already loaded bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_bitCnt     <= '0;
            r_txWord     <= '0;
            r_rxWord     <= '0;
            r_bufData    <= '0;
            r_bufFull    <= 1'b0;
            r_rxData     <= '0;
            r_rxValid    <= 1'b0;
            r_txUnderrun <= 1'b0;
            r_miso       <= 1'b0;
            r_misoOe     <= 1'b0;
        end else begin
            r_rxValid    <= 1'b0;
            r_txUnderrun <= 1'b0;

            if (tx_valid && !r_bufFull) begin
                r_bufFull <= 1'b1;
                r_bufData <= tx_data;
            end

            case (r_state)
                IDLE: begin
                    r_cpol   <= cpol;
                    r_cpha   <= cpha;
                    r_misoOe <= 1'b0;
                    r_miso   <= 1'b0;
                    if (w_ssFall) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_txWord <= w_loadWord;
                    r_miso   <= w_loadWord[FIRST_IDX];
                    if (r_bufFull) begin
                        r_bufFull <= 1'b0;
                    end else begin
                        r_txUnderrun <= 1'b1;
                    end
                    r_bitCnt <= '0;
                    r_misoOe <= 1'b1;
                    r_state  <= SHIFT;
                end
                SHIFT: begin
                    if (w_sampleEdge) begin
                        r_rxWord <= w_rxNext;
                        if (w_lastBit) begin
                            r_rxData  <= w_rxNext;
                            r_rxValid <= 1'b1;
                            r_bitCnt  <= '0;
                            r_txWord  <= w_loadWord;
                            r_miso    <= w_loadWord[FIRST_IDX];
                            if (r_bufFull) begin
                                r_bufFull <= 1'b0;
                            end else begin
                                r_txUnderrun <= 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + CNT_W'(1);
                        end
                    end else if (w_driveEdge) begin
                        r_miso <= r_txWord[w_bitIdx];
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Deselect wins over everything except a word completing on the same edge.
            if (w_ssRise) begin
                r_state  <= IDLE;
                r_misoOe <= 1'b0;
                r_miso   <= 1'b0;
            end
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = r_misoOe;
    assign tx_ready    = !r_bufFull;
    assign rx_data     = r_rxData;
    assign rx_valid    = r_rxValid;
    assign tx_underrun = r_txUnderrun;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: drives two spi_slave_param instances (LSB-first and
// MSB-first, DATA_W=16) from one behavioural SPI master and compares words,
// pulse counts and status outputs against a frame-level reference model.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int W    = 16;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpol;
    logic         cpha;
    logic         ssN;
    logic         sck;
    logic         mosiL;
    logic         mosiM;
    logic         txValid = 1'b0;
    logic [W-1:0] txData  = '0;

    logic         misoL, misoOeL, txReadyL, rxValidL, urSigL, busyL;
    logic         misoM, misoOeM, txReadyM, rxValidM, urSigM, busyM;
    logic [W-1:0] rxDataL, rxDataM;

    int           checks = 0;
    int           passes = 0;

    logic [W-1:0] txQ[$];
    logic [W-1:0] rxQL[$];
    logic [W-1:0] rxQM[$];
    int           urL = 0;
    int           urM = 0;
    logic [W-1:0] lastRx = '0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(W), .MSB_FIRST(0), .SYNC_STAGES(SYNC)) dutLsb (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .ss_n(ssN), .sck(sck),
        .mosi(mosiL), .miso(misoL), .miso_oe(misoOeL), .tx_data(txData),
        .tx_valid(txValid), .tx_ready(txReadyL), .rx_data(rxDataL),
        .rx_valid(rxValidL), .tx_underrun(urSigL), .busy(busyL)
    );

    spi_slave_param #(.DATA_W(W), .MSB_FIRST(1), .SYNC_STAGES(SYNC)) dutMsb (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .ss_n(ssN), .sck(sck),
        .mosi(mosiM), .miso(misoM), .miso_oe(misoOeM), .tx_data(txData),
        .tx_valid(txValid), .tx_ready(txReadyM), .rx_data(rxDataM),
        .rx_valid(rxValidM), .tx_underrun(urSigM), .busy(busyM)
    );

    // Host side: hand the next queued word over whenever both buffers are empty.
    initial begin
        forever begin
            @(negedge clk);
            if (txValid) begin
                txValid = 1'b0;
            end else if (rst && txQ.size() > 0 && txReadyL && txReadyM) begin
                txData  = txQ.pop_front();
                txValid = 1'b1;
            end
        end
    end

    // Collect received words and underrun pulses.
    always @(negedge clk) begin
        if (rxValidL) rxQL.push_back(rxDataL);
        if (rxValidM) rxQM.push_back(rxDataM);
        if (urSigL) urL++;
        if (urSigM) urM++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_oeL"},    32'(misoOeL),  32'd0);
        checkOutput({tag, "_oeM"},    32'(misoOeM),  32'd0);
        checkOutput({tag, "_misoL"},  32'(misoL),    32'd0);
        checkOutput({tag, "_busyL"},  32'(busyL),    32'd0);
        checkOutput({tag, "_busyM"},  32'(busyM),    32'd0);
        checkOutput({tag, "_readyL"}, 32'(txReadyL), 32'd1);
        checkOutput({tag, "_readyM"}, 32'(txReadyM), 32'd1);
    endtask

    // One SS frame. Word j loaded into the shifter is the j-th provided tx word, or zero once
    // the host has run out; a frame loads once at SS fall and again at every completed word.
    task automatic applyStimulus(input int mode, input int nWords, input int nTx,
                                 input int abortBits, input bit resetMid,
                                 input bit useFix, input logic [W-1:0] fixTx,
                                 input logic [W-1:0] fixRx);
        logic [W-1:0] txW[4];
        logic [W-1:0] rxW[4];
        logic [W-1:0] readL[4];
        logic [W-1:0] readM[4];
        int baseL, baseM, urBaseL, urBaseM, completed, totalBits, loads, expUr;
        int w, i, j;
        string tag;

        cpol = mode[1];
        cpha = mode[0];
        sck  = mode[1];
        for (int k = 0; k < 4; k++) begin
            txW[k]   = W'($urandom);
            rxW[k]   = W'($urandom);
            readL[k] = '0;
            readM[k] = '0;
        end
        if (useFix) begin
            txW[0] = fixTx;
            rxW[0] = fixRx;
        end
        for (int k = 0; k < 4; k++) begin
            if (k >= nTx) txW[k] = '0;
        end
        for (int k = 0; k < nTx; k++) txQ.push_back(txW[k]);

        baseL   = rxQL.size();
        baseM   = rxQM.size();
        urBaseL = urL;
        urBaseM = urM;
        repeat (6) @(negedge clk);

        ssN = 1'b0;
        repeat (10) @(negedge clk);

        totalBits = (abortBits > 0) ? abortBits : nWords * W;
        for (int b = 0; b < totalBits; b++) begin
            w = b / W;
            i = b % W;
            j = W - 1 - i;
            if (cpha == 1'b0) begin
                mosiL = rxW[w[1:0]][i[3:0]];
                mosiM = rxW[w[1:0]][j[3:0]];
                repeat (HALF) @(negedge clk);
                readL[w[1:0]][i[3:0]] = misoL;
                readM[w[1:0]][j[3:0]] = misoM;
                sck = ~sck;
                repeat (HALF) @(negedge clk);
                sck = ~sck;
            end else begin
                sck   = ~sck;
                mosiL = rxW[w[1:0]][i[3:0]];
                mosiM = rxW[w[1:0]][j[3:0]];
                repeat (HALF) @(negedge clk);
                readL[w[1:0]][i[3:0]] = misoL;
                readM[w[1:0]][j[3:0]] = misoM;
                sck = ~sck;
                repeat (HALF) @(negedge clk);
            end
            if (b == 1) begin
                checkOutput("midBusyL", 32'(busyL),   32'd1);
                checkOutput("midOeM",   32'(misoOeM), 32'd1);
            end
        end
        repeat (HALF) @(negedge clk);

        completed = (abortBits > 0) ? 0 : nWords;

        if (resetMid) begin
            rst = 1'b0;
            @(negedge clk);
            checkOutput("rstMisoL",  32'(misoL),    32'd0);
            checkOutput("rstOeL",    32'(misoOeL),  32'd0);
            checkOutput("rstReadyL", 32'(txReadyL), 32'd1);
            checkOutput("rstReadyM", 32'(txReadyM), 32'd1);
            checkOutput("rstRxL",    32'(rxDataL),  32'd0);
            checkOutput("rstRxM",    32'(rxDataM),  32'd0);
            checkOutput("rstVldL",   32'(rxValidL), 32'd0);
            checkOutput("rstUrL",    32'(urSigL),   32'd0);
            checkOutput("rstBusyL",  32'(busyL),    32'd0);
            checkOutput("rstBusyM",  32'(busyM),    32'd0);
            lastRx = '0;
            rst = 1'b1;
            repeat (2) @(negedge clk);
            ssN = 1'b1;
            sck = cpol;
            repeat (12) @(negedge clk);
            checkOutput("rstRxCntL", 32'(rxQL.size() - baseL), 32'd0);
            checkIdle("afterRst");
            return;
        end

        ssN = 1'b1;
        repeat (12) @(negedge clk);

        checkOutput("rxCountL", 32'(rxQL.size() - baseL), 32'(completed));
        checkOutput("rxCountM", 32'(rxQM.size() - baseM), 32'(completed));
        for (int k = 0; k < completed; k++) begin
            if (baseL + k < rxQL.size()) begin
                tag = $sformatf("rxWordL%0d", k);
                checkOutput(tag, 32'(rxQL[baseL + k]), 32'(rxW[k]));
            end
            if (baseM + k < rxQM.size()) begin
                tag = $sformatf("rxWordM%0d", k);
                checkOutput(tag, 32'(rxQM[baseM + k]), 32'(rxW[k]));
            end
            tag = $sformatf("misoWordL%0d", k);
            checkOutput(tag, 32'(readL[k]), 32'(txW[k]));
            tag = $sformatf("misoWordM%0d", k);
            checkOutput(tag, 32'(readM[k]), 32'(txW[k]));
        end
        if (completed > 0) lastRx = rxW[completed - 1];
        checkOutput("rxHeldL", 32'(rxDataL), 32'(lastRx));
        checkOutput("rxHeldM", 32'(rxDataM), 32'(lastRx));

        loads = completed + 1;
        expUr = (loads > nTx) ? loads - nTx : 0;
        checkOutput("underrunL", 32'(urL - urBaseL), 32'(expUr));
        checkOutput("underrunM", 32'(urM - urBaseM), 32'(expUr));
        checkIdle("afterFrame");
    endtask

    initial begin
        int nw;
        rst   = 1'b0;
        ssN   = 1'b1;
        sck   = 1'b0;
        cpol  = 1'b0;
        cpha  = 1'b0;
        mosiL = 1'b0;
        mosiM = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetRxL",  32'(rxDataL),  32'd0);
        checkOutput("resetVldM", 32'(rxValidM), 32'd0);
        checkOutput("resetUrL",  32'(urSigL),   32'd0);
        checkIdle("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] mode 0 directed word");
        applyStimulus(0, 1, 1, 0, 1'b0, 1'b1, 16'hA5C3, 16'h1234);

        $display("[TB] all modes, same data");
        for (int m = 0; m < 4; m++) begin
            applyStimulus(m, 1, 2, 0, 1'b0, 1'b1, 16'hA5C3, 16'h1234);
        end

        $display("[TB] three back-to-back words");
        applyStimulus(0, 3, 4, 0, 1'b0, 1'b0, '0, '0);
        applyStimulus(3, 3, 4, 0, 1'b0, 1'b0, '0, '0);

        $display("[TB] empty buffer at select");
        applyStimulus(0, 1, 0, 0, 1'b0, 1'b1, 16'h0000, 16'hBEEF);

        $display("[TB] randomized frames");
        for (int k = 0; k < 6; k++) begin
            nw = int'($urandom_range(3, 1));
            applyStimulus(int'($urandom_range(3, 0)), nw, int'($urandom_range(nw + 1, 0)),
                          0, 1'b0, 1'b0, '0, '0);
        end

        $display("[TB] deselect after 7 bits");
        applyStimulus(1, 1, 1, 7, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 2, 3, 0, 1'b0, 1'b0, '0, '0);

        $display("[TB] reset mid-word");
        applyStimulus(2, 1, 1, 5, 1'b1, 1'b0, '0, '0);
        applyStimulus(2, 1, 2, 0, 1'b0, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
